// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 active-low matrix keypad scanner with debounce and digit cursor.
// Drives one column low at a time, synchronises and samples the rows, classifies
// each full scan and debounces it. Every accepted press appears as a one-cycle
// write strobe carrying the key code (num) and the current digit cursor (sel).
// The cursor then advances modulo 8.
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high
//   row[3:0]  keypad rows, active-low, asynchronous to clk
//   col[3:0]  keypad column drive, active-low, at most one column low
//   write     one-cycle strobe: store num at digit sel
//   sel[2:0]  digit cursor
//   num[3:0]  last accepted key code
//   key_held  high while a debounced press is active
module keypad_entry #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       write,
  output logic [2:0] sel,
  output logic [3:0] num,
  output logic       key_held
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DivW-1:0] DivLast   = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntTarget = CntW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {StIdle, StPressWait, StHeld, StRelWait} state_e;

  logic [3:0]      row_s1_q, row_s2_q;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [15:0]     hits_q, hits_d;
  state_e          state_q, state_d;
  logic [3:0]      cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            write_q, write_d;
  logic [2:0]      sel_q, sel_d;
  logic [3:0]      num_q, num_d;
  logic            key_held_q, key_held_d;

  logic        sample, scan_end;
  logic [4:0]  n_hits;
  logic [3:0]  key_idx;
  logic        is_none, is_single;
  logic        accept;

  // Key code for matrix index {row, col}.
  function automatic logic [3:0] key_code(input logic [3:0] idx);
    logic [3:0] code;
    unique case (idx)
      4'd0:  code = 4'h1;
      4'd1:  code = 4'h2;
      4'd2:  code = 4'h3;
      4'd3:  code = 4'hA;
      4'd4:  code = 4'h4;
      4'd5:  code = 4'h5;
      4'd6:  code = 4'h6;
      4'd7:  code = 4'hB;
      4'd8:  code = 4'h7;
      4'd9:  code = 4'h8;
      4'd10: code = 4'h9;
      4'd11: code = 4'hC;
      4'd12: code = 4'hE;
      4'd13: code = 4'h0;
      4'd14: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Scan timing and row capture.
  always_comb begin
    sample    = (div_q == DivLast);
    scan_end  = sample && (col_idx_q == 2'd3);
    div_d     = sample ? '0 : div_q + DivW'(1);
    col_idx_d = sample ? col_idx_q + 2'd1 : col_idx_q;
    hits_d    = hits_q;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (sample && (col_idx_q == 2'(c))) begin
          hits_d[r*4 + c] = ~row_s2_q[r];
        end
      end
    end
  end

  // Classify the completed scan; hits_d holds the full matrix at the col-3 sample.
  always_comb begin
    n_hits  = '0;
    key_idx = '0;
    for (int i = 0; i < 16; i++) begin
      n_hits = n_hits + 5'(hits_d[i]);
      if (hits_d[i]) begin
        key_idx = 4'(i);
      end
    end
    is_none   = (n_hits == 5'd0);
    is_single = (n_hits == 5'd1);
  end

  // Debounce FSM, stepped once per completed scan.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (scan_end) begin
      unique case (state_q)
        StIdle: begin
          if (is_single) begin
            cand_d = key_idx;
            cnt_d  = CntW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              state_d = StHeld;
              accept  = 1'b1;
            end else begin
              state_d = StPressWait;
            end
          end
        end
        StPressWait: begin
          if (is_single && (key_idx == cand_q)) begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_d == CntTarget) begin
              state_d = StHeld;
              accept  = 1'b1;
            end
          end else if (is_single) begin
            cand_d = key_idx;
            cnt_d  = CntW'(1);
          end else begin
            state_d = StIdle;
          end
        end
        StHeld: begin
          if (is_none) begin
            cnt_d   = CntW'(1);
            // A single clean scan is already a full release.
            state_d = (DEBOUNCE_SCANS == 1) ? StIdle : StRelWait;
          end
        end
        StRelWait: begin
          if (is_none) begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_d == CntTarget) begin
              state_d = StIdle;
            end
          end else begin
            state_d = StHeld;
          end
        end
      endcase
    end
  end

  // Output next-state: cursor advances the cycle after the strobe.
  always_comb begin
    write_d    = accept;
    num_d      = accept ? key_code(cand_d) : num_q;
    sel_d      = write_q ? sel_q + 3'd1 : sel_q;
    key_held_d = (state_d == StHeld) || (state_d == StRelWait);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_s1_q   <= 4'hF;
      row_s2_q   <= 4'hF;
      div_q      <= '0;
      col_idx_q  <= 2'd0;
      hits_q     <= '0;
      state_q    <= StIdle;
      cand_q     <= '0;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      sel_q      <= '0;
      num_q      <= '0;
      key_held_q <= 1'b0;
    end else begin
      row_s1_q   <= row;
      row_s2_q   <= row_s1_q;
      div_q      <= div_d;
      col_idx_q  <= col_idx_d;
      hits_q     <= hits_d;
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      sel_q      <= sel_d;
      num_q      <= num_d;
      key_held_q <= key_held_d;
    end
  end

  assign col      = ~(4'b0001 << col_idx_q);
  assign write    = write_q;
  assign sel      = sel_q;
  assign num      = num_q;
  assign key_held = key_held_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: scoreboard bench for keypad_entry (SCAN_DIV=4, DEBOUNCE_SCANS=3).
// A keypad model turns a 16-bit pressed-key matrix into row levels from col.
// Each scan's matrix is fed to a run-length reference model; expected writes go
// into a queue that a separate monitor pops whenever the DUT strobes write.
module tb_keypad_entry;

  localparam int unsigned Div = 4;
  localparam int unsigned Ds  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic       write;
  logic [2:0] sel;
  logic [3:0] num;
  logic       key_held;

  logic [15:0] keys = '0;  // bit r*4+c set = key at row r / col c pressed

  keypad_entry #(
    .SCAN_DIV      (Div),
    .DEBOUNCE_SCANS(Ds)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .row     (row),
    .col     (col),
    .write   (write),
    .sel     (sel),
    .num     (num),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row[r] = ~|(keys[r*4 +: 4] & ~col);
    end
  end

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] num;
  } exp_t;
  exp_t exp_q[$];

  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  // Reference model state: runs of identical scans decide press and release.
  bit armed    = 1'b1;
  int run_len  = 0;
  int run_key  = -1;
  int none_len = 0;
  int cursor   = 0;
  bit exp_held = 1'b0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    armed    = 1'b1;
    run_len  = 0;
    run_key  = -1;
    none_len = 0;
    cursor   = 0;
    exp_held = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [15:0] pat);
    int n;
    int k;
    n = $countones(pat);
    k = -1;
    for (int i = 0; i < 16; i++) if (pat[i]) k = i;
    if (armed) begin
      if (n == 1) begin
        if (run_len > 0 && k == run_key) run_len++;
        else begin
          run_key = k;
          run_len = 1;
        end
        if (run_len == Ds) begin
          exp_q.push_back('{sel: 3'(cursor), num: keymap[k]});
          cursor   = (cursor + 1) % 8;
          armed    = 1'b0;
          none_len = 0;
          run_len  = 0;
        end
      end else begin
        run_len = 0;
      end
    end else begin
      if (n == 0) begin
        none_len++;
        if (none_len == Ds) armed = 1'b1;
      end else begin
        none_len = 0;
      end
    end
    exp_held = !armed;
  endtask

  // Hold a matrix for cnt whole scans, checking key_held at the end of each.
  task automatic scan(input logic [15:0] pat, input int cnt);
    for (int s = 0; s < cnt; s++) begin
      keys = pat;
      model_step(pat);
      repeat (16) @(negedge clk);
      check("key_held", int'(key_held), int'(exp_held));
    end
  endtask

  // Monitor: pops an expectation on every write strobe.
  initial begin
    bit         prev_wr;
    logic [2:0] prev_sel;
    exp_t       e;
    prev_wr  = 1'b0;
    prev_sel = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_wr = 1'b0;
      end else begin
        if (prev_wr) check("sel_inc", int'(sel), (int'(prev_sel) + 1) % 8);
        if (write) begin
          check("write_pending", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("write_sel", int'(sel), int'(e.sel));
            check("write_num", int'(num), int'(e.num));
          end
        end
        prev_wr  = write;
        prev_sel = sel;
      end
    end
  end

  initial begin
    logic [15:0] pat;
    int          kind, len, a, b;

    repeat (3) @(negedge clk);
    check("rst_col", int'(col), 4'b1110);
    check("rst_write", int'(write), 0);
    check("rst_sel", int'(sel), 0);
    check("rst_num", int'(num), 0);
    check("rst_held", int'(key_held), 0);
    reset = 1'b0;

    // Column walk over two idle scans.
    for (int k = 0; k < 32; k++) begin
      check("col_step", int'(col), int'(~(4'b0001 << ((k / 4) % 4)) & 4'hF));
      @(negedge clk);
    end
    model_step('0);
    model_step('0);

    // Clean hold of '6', long hold, release.
    scan(16'(1) << 6, 13);
    scan('0, 4);

    // Bounce on '8': 2 on, 1 off, 3 on.
    scan(16'(1) << 9, 2);
    scan('0, 1);
    scan(16'(1) << 9, 3);
    scan('0, 3);

    // Nine presses of '0' to wrap the cursor.
    for (int p = 0; p < 9; p++) begin
      scan(16'(1) << 13, 3);
      scan('0, 3);
    end

    // Two keys together, then the second alone.
    scan((16'(1) << 0) | (16'(1) << 9), 3);
    scan(16'(1) << 9, 3);
    scan('0, 3);

    // Reset mid-scan while held; key stays down across reset.
    scan(16'(1) << 6, 4);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_col", int'(col), 4'b1110);
    check("mid_rst_write", int'(write), 0);
    check("mid_rst_sel", int'(sel), 0);
    check("mid_rst_num", int'(num), 0);
    check("mid_rst_held", int'(key_held), 0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    scan(16'(1) << 6, 4);
    scan('0, 3);

    // Random bursts of idle, single and multi-key scans.
    for (int t = 0; t < 14; t++) begin
      kind = $urandom_range(0, 3);
      len  = $urandom_range(1, 5);
      a    = $urandom_range(0, 15);
      b    = (a + $urandom_range(1, 15)) % 16;
      if (kind == 0) pat = '0;
      else if (kind == 3) pat = (16'(1) << a) | (16'(1) << b);
      else pat = 16'(1) << a;
      scan(pat, len);
    end
    scan('0, 4);

    check("leftover_writes", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Matrix-keypad entry block that produces the `write`/`sel`/`num` stream consumed by the eight-digit seven-segment display driver. It scans a 4x4 active-low keypad, synchronises and debounces the rows, and decodes each accepted press to a hex code. Each accepted press is emitted as a single-cycle write strobe addressed to an auto-incrementing digit cursor, so keys typed in sequence fill display digits 0 through 7 and then wrap.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: clk cycles each column is driven; legal range ≥ 4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full scans needed to accept a press or a release; legal range ≥ 1.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `row`  in  4  keypad rows, active-low (externally pulled up); asynchronous to clk.
- `col`  out  4  keypad column drive, active-low, one-hot-zero.
- `write`  out  1  one-cycle strobe: `num` is to be stored at digit `sel`.
- `sel`  out  3  digit cursor (display position).
- `num`  out  4  decoded key code.
- `key_held`  out  1  high while a debounced press is active.

## Operation
- Rows pass through a 2-flop synchroniser before any use.
- Column scan:
  - Column index c cycles 0→1→2→3→0; `col = ~(4'b0001 << c)`.
  - Each slot lasts `SCAN_DIV` cycles.
  - Rows are sampled on the last cycle of each slot.
  - A full scan completes at the col-3 sample.
- Scan classification: NONE (no row low in any column), SINGLE (exactly one row/col intersection low), MULTI (two or more).
- Key map, code = f(row r, col c):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E,0,F,D
- Debounce FSM, evaluated once per completed scan:
  - IDLE:
    - SINGLE k → PRESS_WAIT, candidate = k, count = 1; if `DEBOUNCE_SCANS` = 1, go directly to HELD and accept.
    - NONE or MULTI → stay.
  - PRESS_WAIT:
    - SINGLE equal to candidate → count+1; on reaching `DEBOUNCE_SCANS` → HELD and accept.
    - SINGLE different → candidate replaced, count = 1.
    - NONE or MULTI → IDLE.
  - HELD:
    - NONE → RELEASE_WAIT, count = 1.
    - SINGLE (any key) or MULTI → stay. No rollover: a second key produces nothing until full release.
  - RELEASE_WAIT:
    - NONE → count+1; on reaching `DEBOUNCE_SCANS` → IDLE.
    - SINGLE or MULTI → HELD.
- Accept: `num` ← candidate, `write` pulses, and the cursor increments afterwards, modulo 8 (7→0).
- `num` holds its last accepted value between accepts.
- `key_held` = 1 in HELD and RELEASE_WAIT.

## Timing
- Reset values: `col` = 4'b1110 (column 0 driven), slot counter = 0, `write` = 0, `sel` = 0, `num` = 0, `key_held` = 0, FSM = IDLE.
- Row-to-sample latency: 2 cycles through the synchroniser. The sample point at the end of the slot therefore sees rows settled after `col` changed, which is why `SCAN_DIV` ≥ 4.
- Classification and FSM update happen in the cycle after the col-3 sample.
- `write` is high for exactly 1 cycle, in the cycle after the accepting col-3 sample. `num` and `sel` are valid in that same cycle.
- `sel` during `write` is the pre-increment cursor. `sel` increments in the following cycle.
- `key_held` rises in the same cycle as `write`.
- Nominal press latency: `DEBOUNCE_SCANS` × 4 × `SCAN_DIV` cycles from the first clean scan. Add up to 1 scan for phase alignment.
- Asynchronous reset mid-operation returns every output and all state to reset values immediately. A key still held after reset release is treated as a new press (fresh debounce, new write).

## Test plan
All scenarios use `SCAN_DIV` = 4 and `DEBOUNCE_SCANS` = 3, giving 16 cycles per scan.
- Reset → `col` = 1110, `write` = 0, `sel` = 0, `num` = 0. Then `col` steps 1110→1101→1011→0111→1110, changing every 4 cycles.
- Hold r1/c2 clean → exactly one `write` with `num` = 6, `sel` = 0, after the 3rd complete scan. `sel` = 1 on the next cycle. No further `write` for 10 more scans of hold. `key_held` = 1 throughout the hold, and returns to 0 three scans after release.
- Bounce: r2/c1 ('8') present 2 scans, absent 1 scan, present 3 scans → a single `write` (`num` = 8), occurring at the end of the final 3-scan run.
- Nine press/release cycles of r3/c1 ('0') → `write` with `sel` = 0,1,…,7, then `sel` = 0 on the 9th press (wrap).
- r0/c0 and r2/c1 pressed together → no `write`. Releasing r0/c0 while keeping r2/c1 → `write`, `num` = 8, after 3 scans.
- Assert reset mid-scan while in HELD → all outputs are at reset values in the same cycle. Release reset with the key still held → a new `write` with `sel` = 0 after 3 scans.
